// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared defaults, FSM state and counter width for the data memory responder
package data_mem_responder_pkg;

    localparam int DEPTH_DEF = 128;
    localparam int AW_DEF    = 7;
    localparam int DW_DEF    = 32;
    localparam int CNT_W     = 16;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x DW storage, one synchronous write port and one combinational read port
module dmem_array #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    // No reset on the array; the owner zeroes it by sweeping the write port.
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - processor data memory with clear sweep, backdoor loader, error flag and access counters
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CEN,
    input  logic             WEN,
    input  logic             OEN,
    input  logic [AW-1:0]    A,
    input  logic [DW-1:0]    D,
    output logic [DW-1:0]    Q,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [AW-1:0]    ld_addr,
    input  logic [DW-1:0]    ld_data,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    logic             run;
    logic             proc_rd;
    logic             proc_wr;
    logic             ld_fire;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;

    assign run      = (state_q == ST_RUN);
    assign proc_rd  = run && !CEN && !OEN && WEN;
    assign proc_wr  = run && !CEN && !WEN;
    assign ld_ready = run && CEN;
    assign ld_fire  = ld_valid && ld_ready;

    // Write-port mux: clear sweep, then processor, then backdoor.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = A;
        mem_wdata = D;
        if (!run) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
        end else if (proc_wr) begin
            mem_we    = 1'b1;
        end else if (ld_fire) begin
            mem_we    = 1'b1;
            mem_waddr = ld_addr;
            mem_wdata = ld_data;
        end
        // A write sampled on the same edge as reset must not land.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    dmem_array #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .raddr(A),
        .rdata(mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        err_d     = err_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = ST_RUN;
                    clr_ptr_d = '0;
                end
            end
            ST_RUN: begin
                if (proc_rd && (rd_cnt_q != '1)) begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
                if (proc_wr && (wr_cnt_q != '1)) begin
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                end
                if (proc_wr && !OEN) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            err_q     <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            err_q     <= err_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign Q      = proc_rd ? mem_rdata : '0;
    assign busy   = !run;
    assign err    = err_q;
    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;

endmodule
